// File: rtl/wbc_rr_arbiter_pkg.sv
// Shared definitions for the control-bus round-robin arbiter.
// Master indices, FSM encoding and watchdog/timeout counter width.
package wbc_rr_arbiter_pkg;

    localparam int M_PCI  = 0;
    localparam int M_TURF = 1;
    localparam int M_HK   = 2;
    localparam int M_VIO  = 3;

    localparam int WD_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_TOUT  = 2'd2,
        ST_DRAIN = 2'd3
    } arb_state_t;

    function automatic logic [WD_W-1:0] sat_inc(input logic [WD_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/wbc_rr_arbiter_if.sv
// Control WISHBONE bundle: per-master request side plus the single decoder-facing side.
// 'slave' is the arbiter's view (slave to the masters); 'master' is the environment's view.
interface wbc_rr_arbiter_if #(
    parameter int NM = 4,
    parameter int AW = 20,
    parameter int DW = 32
);
    logic [NM-1:0]        m_cyc_i;
    logic [NM-1:0]        m_stb_i;
    logic [NM-1:0]        m_we_i;
    logic [NM*AW-1:0]     m_adr_i;
    logic [NM*DW-1:0]     m_dat_i;
    logic [NM*DW/8-1:0]   m_sel_i;
    logic [DW-1:0]        m_dat_o;
    logic [NM-1:0]        m_ack_o;
    logic [NM-1:0]        m_err_o;
    logic [NM-1:0]        m_rty_o;

    logic                 s_cyc_o;
    logic                 s_stb_o;
    logic                 s_we_o;
    logic [AW-1:0]        s_adr_o;
    logic [DW-1:0]        s_dat_o;
    logic [DW/8-1:0]      s_sel_o;
    logic [DW-1:0]        s_dat_i;
    logic                 s_ack_i;
    logic                 s_err_i;
    logic                 s_rty_i;

    modport slave (
        input  m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i,
        output m_dat_o, m_ack_o, m_err_o, m_rty_o,
        output s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
        input  s_dat_i, s_ack_i, s_err_i, s_rty_i
    );

    modport master (
        output m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i,
        input  m_dat_o, m_ack_o, m_err_o, m_rty_o,
        input  s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
        output s_dat_i, s_ack_i, s_err_i, s_rty_i
    );
endinterface

// File: rtl/wbc_rr_arbiter_rr_pick.sv
// Round-robin priority selector: first requester scanning upward from (last+1) with wrap.
// Purely combinational, one-hot result, zero when nothing requests.
module wbc_rr_arbiter_rr_pick #(
    parameter int NM = 4,
    parameter int LW = (NM > 1) ? $clog2(NM) : 1
) (
    input  logic [NM-1:0] i_req,
    input  logic [LW-1:0] i_last,
    output logic [NM-1:0] o_gnt
);

    logic          w_found;
    logic [LW-1:0] w_idx;

    always_comb begin
        o_gnt   = '0;
        w_found = 1'b0;
        w_idx   = '0;
        // i = NM wraps back to the last owner itself, so it is considered last.
        for (int i = 1; i <= NM; i++) begin
            w_idx = LW'((int'(i_last) + i) % NM);
            if (!w_found && i_req[w_idx]) begin
                o_gnt[w_idx] = 1'b1;
                w_found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wbc_rr_arbiter.sv
// Round-robin arbiter sharing the control WISHBONE bus between PCI, TURF, HK and VIO masters.
// Grant one cycle after CYC, data path pass-through; watchdog forces ERR on stalled strobes.
module wbc_rr_arbiter
    import wbc_rr_arbiter_pkg::*;
#(
    parameter int NM      = 4,
    parameter int AW      = 20,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    wbc_rr_arbiter_if.slave  wb,
    input  logic [NM-1:0]    mask_i,
    output logic [NM-1:0]    grant_o,
    output logic [WD_W-1:0]  timeout_cnt_o
);

    localparam int LW = (NM > 1) ? $clog2(NM) : 1;
    localparam int SW = DW / 8;

    arb_state_t      r_state, w_state, w_state_nxt;
    logic [NM-1:0]   r_grant, w_grant_nxt;
    logic [LW-1:0]   r_gidx, w_gidx_nxt;
    logic [LW-1:0]   r_last, w_last_nxt;
    logic [WD_W-1:0] r_wd, w_wd_nxt;
    logic [WD_W-1:0] r_tcnt, w_tcnt_nxt;

    logic [NM-1:0]   w_req;
    logic [NM-1:0]   w_pick;
    logic [LW-1:0]   w_pick_idx;
    logic            w_cyc_g;
    logic            w_stb_g;
    logic            w_resp;
    logic            w_tout_hit;

    logic            w_s_cyc, w_s_stb, w_s_we;
    logic [AW-1:0]   w_s_adr;
    logic [DW-1:0]   w_s_dat;
    logic [SW-1:0]   w_s_sel;
    logic [DW-1:0]   w_m_dat;
    logic [NM-1:0]   w_m_ack, w_m_err, w_m_rty;

    assign w_req = wb.m_cyc_i & ~mask_i;

    wbc_rr_arbiter_rr_pick #(.NM(NM), .LW(LW)) u_pick (
        .i_req  (w_req),
        .i_last (r_last),
        .o_gnt  (w_pick)
    );

    always_comb begin
        w_pick_idx = '0;
        for (int i = 0; i < NM; i++) begin
            if (w_pick[i]) w_pick_idx = LW'(i);
        end
    end

    assign w_cyc_g = wb.m_cyc_i[r_gidx];
    assign w_stb_g = wb.m_stb_i[r_gidx];
    assign w_resp  = wb.s_ack_i | wb.s_err_i | wb.s_rty_i;

    // The timeout cycle is a BUSY cycle promoted to TOUT; a same-cycle slave response wins.
    assign w_tout_hit = (r_state == ST_BUSY) && w_cyc_g && w_stb_g && !w_resp &&
                        (r_wd == WD_W'(TIMEOUT));
    assign w_state    = w_tout_hit ? ST_TOUT : r_state;

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_gidx_nxt  = r_gidx;
        w_last_nxt  = r_last;
        w_wd_nxt    = '0;
        w_tcnt_nxt  = r_tcnt;
        w_s_cyc     = 1'b0;
        w_s_stb     = 1'b0;
        w_s_we      = 1'b0;
        w_s_adr     = '0;
        w_s_dat     = '0;
        w_s_sel     = '0;
        w_m_dat     = '0;
        w_m_ack     = '0;
        w_m_err     = '0;
        w_m_rty     = '0;

        case (w_state)
            ST_IDLE: begin
                if (|w_req) begin
                    w_grant_nxt = w_pick;
                    w_gidx_nxt  = w_pick_idx;
                    w_state_nxt = ST_BUSY;
                end
            end

            ST_BUSY: begin
                w_s_cyc          = w_cyc_g;
                w_s_stb          = w_stb_g;
                w_s_we           = wb.m_we_i[r_gidx];
                w_s_adr          = wb.m_adr_i[int'(r_gidx)*AW +: AW];
                w_s_dat          = wb.m_dat_i[int'(r_gidx)*DW +: DW];
                w_s_sel          = wb.m_sel_i[int'(r_gidx)*SW +: SW];
                w_m_dat          = wb.s_dat_i;
                w_m_ack[r_gidx]  = wb.s_ack_i;
                w_m_err[r_gidx]  = wb.s_err_i;
                w_m_rty[r_gidx]  = wb.s_rty_i;
                w_wd_nxt         = (w_resp || !w_stb_g) ? '0 : r_wd + 1'b1;
                if (!w_cyc_g) begin
                    w_last_nxt  = r_gidx;
                    w_grant_nxt = '0;
                    w_wd_nxt    = '0;
                    w_state_nxt = ST_IDLE;
                end
            end

            ST_TOUT: begin
                w_m_err[r_gidx] = 1'b1;
                w_tcnt_nxt      = sat_inc(r_tcnt);
                w_state_nxt     = ST_DRAIN;
            end

            ST_DRAIN: begin
                if (!w_cyc_g) begin
                    w_last_nxt  = r_gidx;
                    w_grant_nxt = '0;
                    w_state_nxt = ST_IDLE;
                end
            end

            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_gidx  <= '0;
            r_last  <= LW'(NM - 1);
            r_wd    <= '0;
            r_tcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_gidx  <= w_gidx_nxt;
            r_last  <= w_last_nxt;
            r_wd    <= w_wd_nxt;
            r_tcnt  <= w_tcnt_nxt;
        end
    end

    assign wb.s_cyc_o    = w_s_cyc;
    assign wb.s_stb_o    = w_s_stb;
    assign wb.s_we_o     = w_s_we;
    assign wb.s_adr_o    = w_s_adr;
    assign wb.s_dat_o    = w_s_dat;
    assign wb.s_sel_o    = w_s_sel;
    assign wb.m_dat_o    = w_m_dat;
    assign wb.m_ack_o    = w_m_ack;
    assign wb.m_err_o    = w_m_err;
    assign wb.m_rty_o    = w_m_rty;
    assign grant_o       = r_grant;
    assign timeout_cnt_o = r_tcnt;

endmodule

// File: doc/wbc_rr_arbiter.md
Name: wbc_rr_arbiter

Overview:
Round-robin arbiter that shares the 20-bit control WISHBONE bus between four masters: PCI control, TURF control, housekeeping and VIO debug. Grants exactly one master at a time and forwards its cycle to the single slave-side port that feeds address decode. A watchdog terminates stalled cycles with ERR, so a missing slave cannot hang PCI or TURF. Clocked on the control-bus clock and placed between the master ports and the slave decoder.

Parameters:
NM, 4, number of masters (index 0 = PCI, 1 = TURF, 2 = HK, 3 = VIO).
AW, 20, address width.
DW, 32, data width.
TIMEOUT, 255, cycles with STB high and no ACK/ERR/RTY before a forced ERR; range 1..65535.

Ports:
clk_i  in  1  control WISHBONE clock.
rst_n_i  in  1  reset; synchronous, active-low.
m_cyc_i  in  NM  per-master CYC.
m_stb_i  in  NM  per-master STB.
m_we_i  in  NM  per-master WE.
m_adr_i  in  NM*AW  packed addresses; master k at [k*AW +: AW].
m_dat_i  in  NM*DW  packed write data.
m_sel_i  in  NM*DW/8  packed byte selects.
m_dat_o  out  DW  read data, broadcast to all masters.
m_ack_o  out  NM  ACK to the granted master only.
m_err_o  out  NM  ERR to the granted master only (slave or timeout).
m_rty_o  out  NM  RTY to the granted master only.
mask_i  in  NM  1 = master excluded from arbitration.
s_cyc_o  out  1  slave-side CYC.
s_stb_o  out  1  slave-side STB.
s_we_o  out  1  slave-side WE.
s_adr_o  out  AW  slave-side address.
s_dat_o  out  DW  slave-side write data.
s_sel_o  out  DW/8  slave-side byte selects.
s_dat_i  in  DW  slave read data.
s_ack_i  in  1  slave ACK.
s_err_i  in  1  slave ERR.
s_rty_i  in  1  slave RTY.
grant_o  out  NM  one-hot current grant; 0 when idle.
timeout_cnt_o  out  16  saturating count of forced timeouts.

Behaviour:
- Reset (rst_n_i = 0 at a clk_i edge): state IDLE; grant_o = 0; last-grant pointer = NM-1, so master 0 wins first. All s_* outputs and m_ack/err/rty_o are 0; m_dat_o = 0; timeout_cnt_o = 0; watchdog = 0. Reset mid-cycle drops s_cyc_o on the next edge and generates no response.
- States:
  - IDLE: req = m_cyc_i & ~mask_i. If req ≠ 0, register the grant and go to BUSY. The winner is the first set bit scanning from (last+1) mod NM upward with wrap; latency is 1 cycle from CYC to grant_o.
  - BUSY: s_cyc_o = m_cyc_i[g] and s_stb_o = m_stb_i[g]; we/adr/dat/sel are muxed from master g; combinational pass-through, no added latency. s_ack/err/rty_i are routed combinationally to bit g of the matching m_* outputs; m_dat_o = s_dat_i.
    - If m_cyc_i[g] falls: update last = g, clear grant, go to IDLE. This inserts one dead cycle between owners.
    - Burst and back-to-back strobes under one CYC keep the grant; no preemption.
    - Masking a master while it is granted does not revoke the grant.
  - TOUT: entered when watchdog == TIMEOUT while in BUSY.
    - In that cycle m_err_o[g] = 1 for exactly one cycle, and s_cyc_o/s_stb_o are forced to 0.
    - timeout_cnt_o increments, saturating at 0xFFFF.
    - Go to DRAIN.
  - DRAIN: s_cyc_o = 0; no responses are forwarded. Wait for m_cyc_i[g] = 0, then set last = g and go to IDLE.
- Watchdog: 16-bit counter.
  - Cleared in IDLE, and on any cycle where s_ack_i|s_err_i|s_rty_i is high or m_stb_i[g] is low.
  - Otherwise increments.
  - A slave response arriving in the same cycle the watchdog hits TIMEOUT wins: the response is forwarded and no ERR is raised.
- Masked and idle masters always see ack/err/rty = 0.
- A single requester is re-granted after the one dead cycle. No starvation: any continuously requesting unmasked master is granted within NM-1 tenures.

Decomposition:
- Shared package: master index constants (PCI = 0, TURF = 1, HK = 2, VIO = 3), FSM state encoding (IDLE, BUSY, TOUT, DRAIN), timeout counter width (16).
- One sub-module, rr_pick: combinational round-robin priority selector.
  - Inputs: req[NM], last pointer. Output: one-hot winner.
  - Reusable for the future data-bus arbiter.

Test Plan:
- Reset, then m_cyc_i = 4'b0110 → grant_o = 4'b0010 one cycle later. When master 1 drops CYC, the next grant after one dead cycle is 4'b0100.
- All four hold CYC, each releasing after 3 cycles → grant sequence 0001, 0010, 0100, 1000, 0001 with one idle cycle between each.
- mask_i = 4'b0001, m_cyc_i = 4'b0011 → master 0 is never granted. Unmask while master 1 is granted → master 1 keeps the grant until it releases, then master 0 is granted.
- TIMEOUT = 8, master 2 strobes and the slave never acks → m_err_o = 4'b0100 exactly 9 cycles after STB rises, s_cyc_o = 0 in that cycle, timeout_cnt_o = 1; the FSM stays in DRAIN until master 2 drops CYC.
- TIMEOUT = 8, s_ack_i arrives in the 9th cycle → m_ack_o[g] = 1, no ERR, timeout_cnt_o unchanged.
- Master 0 read of adr 0x10004, slave returns 0xDEADBEEF with ACK → m_dat_o = 0xDEADBEEF and m_ack_o = 4'b0001 in the same cycle. Assert rst_n_i = 0 mid-cycle → all outputs 0 next edge.
